// File: rtl/arm_pkg.sv
// Shared ARM constants for the branch/PC stage and later execute stages:
// condition encodings, NZCV bit positions, PC increments and FSM state codes.
package arm_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [31:0] PC_INC      = 32'd4;
    localparam logic [31:0] PC_PIPE_OFS = 32'd8;

    // Kept as plain constants so older netlists can match the encoding.
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// Decode-to-PC-stage bundle: branch request, stall and flags in; fetch PC,
// flush and link-register write out.
interface branch_pc_unit_if;
    logic        stall;
    logic        br_valid;
    logic        br_link;
    logic [3:0]  br_cond;
    logic [3:0]  flags;
    logic [31:0] br_pc;
    logic [31:0] br_offset;
    logic [31:0] pc_out;
    logic        flush;
    logic        br_taken;
    logic        lr_we;
    logic [31:0] lr_data;

    modport master (
        output stall, br_valid, br_link, br_cond, flags, br_pc, br_offset,
        input  pc_out, flush, br_taken, lr_we, lr_data
    );

    modport slave (
        input  stall, br_valid, br_link, br_cond, flags, br_pc, br_offset,
        output pc_out, flush, br_taken, lr_we, lr_data
    );
endinterface

// File: rtl/branch_pc_unit_cond_check.sv
// ARM condition-code evaluator: decides whether a cond field passes for the
// given NZCV flags. Purely combinational so execute can reuse it.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] br_cond,
    input  logic [3:0] flags,
    output logic       cond_pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_pass = 1'b0;
        case (br_cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = !c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = !v;
            COND_HI: cond_pass = c & !z;
            COND_LS: cond_pass = !c | z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = !z & (n == v);
            COND_LE: cond_pass = z | (n != v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch PC owner and branch resolver: redirects fetch on taken B/BL, holds
// flush for FLUSH_CYCLES cycles and emits the R14 write for BL.
module branch_pc_unit
    import arm_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    branch_pc_unit_if.slave  bus
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    logic [0:0]  state;
    logic [2:0]  flush_cnt;
    logic [31:0] pc_q;
    logic        flush_q;
    logic        br_taken_q;
    logic        lr_we_q;
    logic [31:0] lr_data_q;
    logic        cond_pass;
    logic        take_branch;
    logic [31:0] target;

    cond_check u_cond_check (
        .br_cond   (bus.br_cond),
        .flags     (bus.flags),
        .cond_pass (cond_pass)
    );

    assign take_branch = bus.br_valid & cond_pass;
    assign target      = word_align(bus.br_pc + PC_PIPE_OFS + bus.br_offset);

    // br_taken/lr_we default low so they can only ever pulse for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_RUN;
            flush_cnt  <= 3'd0;
            pc_q       <= RESET_VECTOR;
            flush_q    <= 1'b0;
            br_taken_q <= 1'b0;
            lr_we_q    <= 1'b0;
            lr_data_q  <= 32'd0;
        end else begin
            br_taken_q <= 1'b0;
            lr_we_q    <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (!bus.stall) begin
                        if (take_branch) begin
                            pc_q       <= target;
                            br_taken_q <= 1'b1;
                            flush_q    <= 1'b1;
                            flush_cnt  <= FLUSH_INIT;
                            if (bus.br_link) begin
                                lr_we_q   <= 1'b1;
                                lr_data_q <= bus.br_pc + PC_INC;
                            end
                            state <= (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
                        end else begin
                            pc_q    <= pc_q + PC_INC;
                            flush_q <= 1'b0;
                        end
                    end
                end
                // Younger instructions are being squashed, so br_valid is ignored here.
                ST_FLUSH: begin
                    if (!bus.stall) begin
                        pc_q <= pc_q + PC_INC;
                        if (flush_cnt == 3'd0) begin
                            flush_q <= 1'b0;
                            state   <= ST_RUN;
                        end else begin
                            flush_cnt <= flush_cnt - 3'd1;
                        end
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign bus.pc_out   = pc_q;
    assign bus.flush    = flush_q;
    assign bus.br_taken = br_taken_q;
    assign bus.lr_we    = lr_we_q;
    assign bus.lr_data  = lr_data_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: directed branch/stall/reset vectors
// with hand-computed expected outputs, plus a wrap-around reset-vector instance.
module tb_branch_pc_unit;
    import arm_pkg::*;

    localparam logic [31:0] LR_BL = 32'h0100_0004;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        flush;
        logic        taken;
        logic        lr_we;
        logic [31:0] lr;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic reset_w;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    branch_pc_unit_if bus();
    branch_pc_unit_if bus_w();

    branch_pc_unit #(.RESET_VECTOR(32'h0000_0000), .FLUSH_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    branch_pc_unit #(.RESET_VECTOR(32'hFFFF_FFFC), .FLUSH_CYCLES(2)) dut_w (
        .clk   (clk),
        .reset (reset_w),
        .bus   (bus_w.slave)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(
        input string name, input logic rst, input logic st, input logic v, input logic l,
        input logic [3:0] c, input logic [3:0] f, input logic [31:0] bpc, input logic [31:0] off,
        input logic [31:0] epc, input logic efl, input logic etk, input logic ewe, input logic [31:0] elr);
        exp_t e;
        @(negedge clk);
        reset         = rst;
        bus.stall     = st;
        bus.br_valid  = v;
        bus.br_link   = l;
        bus.br_cond   = c;
        bus.flags     = f;
        bus.br_pc     = bpc;
        bus.br_offset = off;
        e = '{name: name, pc: epc, flush: efl, taken: etk, lr_we: ewe, lr: elr};
        sb.push_back(e);
    endtask

    task automatic idle(input string name, input logic [31:0] epc, input logic efl, input logic [31:0] elr);
        applyStimulus(name, 1'b0, 1'b0, 1'b0, 1'b0, COND_AL, 4'h0, 32'h0, 32'h0, epc, efl, 1'b0, 1'b0, elr);
    endtask

    // Monitor: each cycle's outputs are compared against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput({e.name, " pc_out"},   bus.pc_out,   e.pc);
                checkOutput({e.name, " flush"},    bus.flush,    e.flush);
                checkOutput({e.name, " br_taken"}, bus.br_taken, e.taken);
                checkOutput({e.name, " lr_we"},    bus.lr_we,    e.lr_we);
                checkOutput({e.name, " lr_data"},  bus.lr_data,  e.lr);
            end
        end
    end

    initial begin
        reset         = 1'b1;
        reset_w       = 1'b1;
        bus.stall     = 1'b0;
        bus.br_valid  = 1'b0;
        bus.br_link   = 1'b0;
        bus.br_cond   = COND_AL;
        bus.flags     = 4'h0;
        bus.br_pc     = 32'h0;
        bus.br_offset = 32'h0;
        bus_w.stall     = 1'b0;
        bus_w.br_valid  = 1'b0;
        bus_w.br_link   = 1'b0;
        bus_w.br_cond   = COND_AL;
        bus_w.flags     = 4'h0;
        bus_w.br_pc     = 32'h0;
        bus_w.br_offset = 32'h0;

        applyStimulus("reset", 1, 0, 0, 0, COND_AL, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
        idle("run1", 32'h4, 0, 32'h0);
        idle("run2", 32'h8, 0, 32'h0);
        idle("run3", 32'hC, 0, 32'h0);

        applyStimulus("bl_al", 0, 0, 1, 1, COND_AL, 4'h0, 32'h0100_0000, 32'hFF55_5554,
                      32'h0055_555C, 1, 1, 1, LR_BL);
        idle("bl_flush2", 32'h0055_5560, 1, LR_BL);
        idle("bl_flush_end", 32'h0055_5564, 0, LR_BL);

        applyStimulus("beq_taken", 0, 0, 1, 0, COND_EQ, 4'b0100, 32'h100, 32'hFFFF_FFF8,
                      32'h100, 1, 1, 0, LR_BL);
        applyStimulus("br_in_flush", 0, 0, 1, 0, COND_AL, 4'h0, 32'h200, 32'h1000,
                      32'h104, 1, 0, 0, LR_BL);
        idle("beq_flush_end", 32'h108, 0, LR_BL);
        applyStimulus("beq_not_taken", 0, 0, 1, 0, COND_EQ, 4'b0000, 32'h100, 32'hFFFF_FFF8,
                      32'h10C, 0, 0, 0, LR_BL);

        applyStimulus("b_al", 0, 0, 1, 0, COND_AL, 4'h0, 32'h400, 32'h40, 32'h448, 1, 1, 0, LR_BL);
        for (int i = 0; i < 3; i++)
            applyStimulus("stall_flush", 0, 1, 0, 0, COND_AL, 4'h0, 32'h0, 32'h0, 32'h448, 1, 0, 0, LR_BL);
        idle("stall_resume", 32'h44C, 1, LR_BL);
        idle("stall_flush_end", 32'h450, 0, LR_BL);

        applyStimulus("br_with_stall", 0, 1, 1, 1, COND_AL, 4'h0, 32'h800, 32'h100,
                      32'h450, 0, 0, 0, LR_BL);
        idle("after_stall", 32'h454, 0, LR_BL);

        applyStimulus("bgt_taken", 0, 0, 1, 0, COND_GT, 4'b1001, 32'h1000, 32'h10,
                      32'h1018, 1, 1, 0, LR_BL);
        idle("bgt_flush2", 32'h101C, 1, LR_BL);
        idle("bgt_flush_end", 32'h1020, 0, LR_BL);
        applyStimulus("bnv", 0, 0, 1, 1, COND_NV, 4'h0, 32'h1020, 32'h40, 32'h1024, 0, 0, 0, LR_BL);
        applyStimulus("bhi_not", 0, 0, 1, 0, COND_HI, 4'b0110, 32'h1024, 32'h40, 32'h1028, 0, 0, 0, LR_BL);
        applyStimulus("bmi_align", 0, 0, 1, 0, COND_MI, 4'b1000, 32'h3000, 32'h3,
                      32'h3008, 1, 1, 0, LR_BL);
        idle("bmi_flush2", 32'h300C, 1, LR_BL);
        idle("bmi_flush_end", 32'h3010, 0, LR_BL);

        applyStimulus("blt_taken", 0, 0, 1, 0, COND_LT, 4'b1000, 32'h2000, 32'h0,
                      32'h2008, 1, 1, 0, LR_BL);
        idle("blt_flush2", 32'h200C, 1, LR_BL);
        applyStimulus("reset_mid_flush", 1, 0, 0, 0, COND_AL, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
        idle("post_reset", 32'h4, 0, 32'h0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drain", sb.size(), 32'd0);

        @(negedge clk);
        reset_w = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("wrap reset pc_out", bus_w.pc_out, 32'hFFFF_FFFC);
        @(negedge clk);
        reset_w = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("wrap pc_out", bus_w.pc_out, 32'h0000_0000);
        checkOutput("wrap flush", bus_w.flush, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Program-counter and branch-resolution stage directly downstream of Branch_Ext.
- Consumes the 32-bit sign-extended, word-shifted offset from Branch_Ext together with the branch's cond field and the current NZCV flags.
- Decides whether the branch is taken and computes the ARM target (branch PC + 8 + offset).
- Owns the fetch PC, sequences the pipeline flush after a taken branch, and issues the link-register write for BL.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles `flush` stays high after a taken branch (squashes IF/ID); legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard stall; freezes PC and the flush counter.
- br_valid  input  1  decode presents a B/BL instruction this cycle.
- br_link  input  1  L bit (1 = BL).
- br_cond  input  4  ARM condition field [31:28].
- flags  input  4  NZCV from CPSR, N = bit 3.
- br_pc  input  32  address of the branch instruction.
- br_offset  input  32  Branch_Ext output (already sign-extended and shifted left by 2).
- pc_out  output  32  fetch address.
- flush  output  1  squash younger instructions.
- br_taken  output  1  one-cycle pulse, branch resolved taken.
- lr_we  output  1  one-cycle write enable for R14.
- lr_data  output  32  link value.

Behaviour:
- All outputs are registered.
- Reset (synchronous, highest priority, including mid-flush):
  - pc_out = RESET_VECTOR; flush = br_taken = lr_we = 0; lr_data = 0.
  - State = RUN; flush counter = 0.
- Condition evaluation (combinational, cond_pass):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 4'b1111 (NV) 0.
- Target:
  - target = br_pc + 32'd8 + br_offset, modulo 2^32 (wrap-around silently).
  - target[1:0] forced to 2'b00.
- State RUN:
  - If stall: all registers hold; br_taken and lr_we drive 0. A branch coincident with stall is ignored; decode must re-present it.
  - Else if br_valid & cond_pass:
    - pc_out <= target; br_taken <= 1; flush <= 1; counter <= FLUSH_CYCLES-1.
    - If br_link: lr_we <= 1, lr_data <= br_pc + 4.
    - Go to FLUSH, or stay in RUN if FLUSH_CYCLES == 1 (flush then lasts exactly one cycle).
  - Else: pc_out <= pc_out + 4 (wraps 0xFFFF_FFFC -> 0x0000_0000); br_taken, lr_we <= 0.
- State FLUSH:
  - flush stays 1; br_valid is ignored, since those instructions are being squashed.
  - pc_out keeps incrementing by 4 from the target, unless stall.
  - Stall freezes both pc_out and the counter.
  - counter == 0 and no stall: flush <= 0, go to RUN.
- Latency:
  - Branch at cycle N -> pc_out = target at N+1.
  - flush high for cycles N+1 .. N+FLUSH_CYCLES (stall cycles extend the window).
  - br_taken and lr_we high only in N+1.
- A not-taken branch behaves exactly like a non-branch cycle: no flush, no lr_we.

Decomposition:
- Package arm_pkg:
  - 4-bit cond encodings COND_EQ..COND_NV.
  - NZCV bit-index constants.
  - PC_INC = 4, PC_PIPE_OFS = 8.
  - FSM enum {RUN, FLUSH}.
- Sub-module cond_check (br_cond, flags -> cond_pass), purely combinational and reused later by the data-processing stage.
- Top level holds the PC register, target adder, FSM and counter.

Test Plan:
- Reset then 3 free-running cycles -> pc_out 0x0, 0x4, 0x8, 0xC; flush = 0 throughout.
- BL/AL with br_pc = 0x0100_0000 and br_offset = 0xFF55_5554 (Branch_Ext of 24'b1101_0101_0101_0101_0101_0101) -> next cycle:
  - pc_out = 0x0055_555C; br_taken = 1; lr_we = 1; lr_data = 0x0100_0004.
  - flush high for exactly 2 cycles.
- BEQ (cond 0000), flags Z = 1, br_pc = 0x100, br_offset = 0xFFFF_FFF8 -> pc_out = 0x100; lr_we = 0.
  - Same instruction with Z = 0 -> pc_out = previous + 4; no flush.
- During FLUSH, present br_valid AL with a different offset -> ignored; pc_out continues +4 from the first target.
- stall for 3 cycles in mid-FLUSH -> pc_out and flush frozen; flush ends 3 cycles later than unstalled.
  - Branch presented with stall = 1 -> no effect.
- Force pc_out to 0xFFFF_FFFC via RESET_VECTOR = 0xFFFF_FFFC -> next pc_out = 0x0.
  - Assert reset during FLUSH -> next cycle pc_out = RESET_VECTOR, flush = 0.
